// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: state enum, default sizes and latency helper for mac_array_sequencer
package mac_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  localparam int LANES_DEF   = 10;
  localparam int P_W_DEF     = 17;
  localparam int ADDR_W_DEF  = 4;
  localparam int RD_LAT_DEF  = 2;
  localparam int DSP_LAT_DEF = 3;
  function automatic int lat(input int rd, input int dsp);
    return rd + dsp;
  endfunction
endpackage

// File: rtl/mac_seq_lat_pipe.sv
// mac_seq_lat_pipe: depth-DEPTH {valid, addr} shift register with synchronous flush
module mac_seq_lat_pipe
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = lat(RD_LAT_DEF, DSP_LAT_DEF),
  parameter int AW    = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_v,
  input  logic [AW-1:0] in_addr,
  output logic          out_v,
  output logic [AW-1:0] out_addr,
  output logic          any_v
);
  logic [DEPTH-1:0]         v_q, v_d;
  logic [DEPTH-1:0][AW-1:0] a_q, a_d;
  always_comb begin
    v_d[0] = in_v && !flush;
    a_d[0] = in_addr;
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i] = v_q[i-1] && !flush;
      a_d[i] = a_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      a_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
    end
  end
  assign out_v    = v_q[DEPTH-1];
  assign out_addr = a_q[DEPTH-1];
  assign any_v    = |v_q;
endmodule

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer: sweeps operand memories, tracks read+DSP latency, tags lane results (MAC_SEQ_ACCUM_EN adds per-lane accumulators)
module mac_array_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int P_W     = P_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int DSP_LAT = DSP_LAT_DEF
`ifdef MAC_SEQ_ACCUM_EN
  , parameter int ACC_W = P_W + ADDR_W + 1
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      count,
  input  logic                 hold,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 mem_ena,
  output logic                 mem_wea,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [LANES*P_W-1:0] dsp_p,
  output logic                 res_valid,
  output logic [ADDR_W-1:0]    res_addr,
  output logic [LANES*P_W-1:0] res_data
`ifdef MAC_SEQ_ACCUM_EN
  , output logic [LANES*ACC_W-1:0] acc_data,
  output logic                   acc_valid
`endif
);
  localparam int LAT = lat(RD_LAT, DSP_LAT);
  localparam logic [ADDR_W:0] CMAX = {1'b1, {ADDR_W{1'b0}}};
  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d, ra_q, ra_d, tail_a;
  logic [ADDR_W:0]        rem_q, rem_d, cnt_sat;
  logic                   busy_q, busy_d, done_q, done_d, ab_q, ab_d, pend_q, pend_d;
  logic                   rv_q, rv_d, iss, stop, tail_v, pipe_any;
  logic [LANES*P_W-1:0]   rd_q, rd_d;
  mac_seq_lat_pipe #(.DEPTH(LAT), .AW(ADDR_W)) u_pipe (
    .clk(clk), .reset(reset), .flush(stop), .in_v(iss), .in_addr(addr_q),
    .out_v(tail_v), .out_addr(tail_a), .any_v(pipe_any)
  );
  always_comb begin
    cnt_sat = count > CMAX ? CMAX : count;
    stop    = abort && (state_q == ISSUE || state_q == DRAIN);
    iss     = state_q == ISSUE && !hold && !abort;
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    ab_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = base_addr;
        rem_d   = cnt_sat;
        busy_d  = 1'b1;
        state_d = cnt_sat == '0 ? DONE : ISSUE;
      end
      ISSUE: if (iss) begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == (ADDR_W+1)'(1) ? DRAIN : ISSUE;
      end
      DRAIN: state_d = pipe_any ? DRAIN : DONE;
      DONE: begin
        done_d  = 1'b1;
        ab_d    = pend_q;
        pend_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (stop) begin
      state_d = DONE;
      pend_d  = 1'b1;
    end
    rv_d = tail_v && !stop;
    ra_d = tail_v ? tail_a : ra_q;
    rd_d = tail_v ? dsp_p : rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
      pend_q  <= 1'b0;
      rv_q    <= 1'b0;
      ra_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
      pend_q  <= pend_d;
      rv_q    <= rv_d;
      ra_q    <= ra_d;
      rd_q    <= rd_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = ab_q;
  assign mem_ena   = state_q == ISSUE || state_q == DRAIN;
  assign mem_wea   = 1'b0;
  assign mem_addr  = addr_q;
  assign res_valid = rv_q;
  assign res_addr  = ra_q;
  assign res_data  = rd_q;
`ifdef MAC_SEQ_ACCUM_EN
  logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;
  logic                        accv_q, accv_d;
  always_comb begin
    accv_d = state_q == DONE && !pend_q;
    for (int i = 0; i < LANES; i++)
      acc_d[i] = (state_q == IDLE && start) ? '0 :
                 rv_q ? acc_q[i] + ACC_W'($signed(rd_q[i*P_W +: P_W])) : acc_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      accv_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      accv_q <= accv_d;
    end
  end
  assign acc_data  = acc_q;
  assign acc_valid = accv_q;
`endif
endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb_mac_array_sequencer: scoreboard bench for issue order, result tagging, latency, hold, abort and reset
module tb_mac_array_sequencer;
  localparam int LANES = 10, P_W = 17, AW = 4, LAT = 5, DW = LANES * P_W, ACC_W = P_W + AW + 1;
  typedef struct {int cyc; logic [AW-1:0] a; logic [DW-1:0] d;} res_t;
  typedef struct {int cyc; bit ab; int blen; bit has_acc; int acc0;} done_t;
  typedef struct {int cyc; logic [AW-1:0] a;} iss_t;
  logic clk = 0, reset = 1, start = 0, hold = 0, abort = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic busy, done, aborted, mem_ena, mem_wea, res_valid;
  logic [AW-1:0] mem_addr, res_addr;
  logic [DW-1:0] dsp_p, res_data;
`ifdef MAC_SEQ_ACCUM_EN
  logic [LANES*ACC_W-1:0] acc_data;
  logic                   acc_valid;
`endif
  mac_array_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .hold(hold), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data)
`ifdef MAC_SEQ_ACCUM_EN
    , .acc_data(acc_data), .acc_valid(acc_valid)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [P_W-1:0] pv(input int a, input int l);
    int x, y, z;
    if (l == 0 && a < 3) begin
      x = a == 0 ? 2 : a == 1 ? -1 : 5;
      y = a == 0 ? 3 : a == 1 ? 4 : 5;
      z = a == 0 ? 1 : a == 1 ? 0 : -5;
    end else begin
      x = a - l;
      y = l + 2;
      z = a * l - 9;
    end
    return P_W'(x * y + z);
  endfunction
  function automatic logic [DW-1:0] pk(input int a);
    logic [DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*P_W +: P_W] = pv(a, l);
    return r;
  endfunction
  logic [AW-1:0] hist [LAT];
  always @(posedge clk) begin
    hist[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
  end
  assign dsp_p = pk(int'(hist[LAT-1]));
  res_t  exp_q[$];
  done_t dq[$];
  iss_t  iq[$];
  int errors = 0, checks = 0, rise = 0;
  logic pb = 0;
  bit chk_idle = 0, chk_rst = 0, chk_end = 0, use_acc = 0;
  res_t me;
  done_t md;
  iss_t mi;
  always @(negedge clk) begin
    if (chk_rst) begin
      checks++;
      if ({busy, done, aborted, mem_ena, mem_wea, res_valid, mem_addr, res_addr} !== '0) begin
        errors++;
        $display("FAIL reset_ctrl got=%h want=0", {busy, done, aborted, mem_ena, mem_wea, res_valid, mem_addr, res_addr});
      end
      checks++;
      if (res_data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", res_data); end
    end
    if (!reset) begin
      checks++;
      if (mem_wea !== 1'b0) begin errors++; $display("FAIL mem_wea got=%b want=0", mem_wea); end
      if (chk_idle) begin
        checks++;
        if ({mem_ena, res_valid} !== 2'b00) begin
          errors++;
          $display("FAIL idle_quiet cyc=%0d mem_ena=%b res_valid=%b want 0,0", cyc, mem_ena, res_valid);
        end
      end
      if (busy && !pb) rise = cyc;
      pb = busy;
      if (iq.size() > 0 && iq[0].cyc == cyc) begin
        mi = iq.pop_front();
        checks++;
        if ({mem_ena, mem_addr} !== {1'b1, mi.a}) begin
          errors++;
          $display("FAIL issue cyc=%0d got ena=%b addr=%0d want ena=1 addr=%0d", cyc, mem_ena, mem_addr, mi.a);
        end
      end
      if (res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected cyc=%0d addr=%0d want none", cyc, res_addr);
        end else begin
          me = exp_q.pop_front();
          if (cyc != me.cyc) begin errors++; $display("FAIL res_cycle got=%0d want=%0d", cyc, me.cyc); end
          checks++;
          if (res_addr !== me.a) begin errors++; $display("FAIL res_addr got=%0d want=%0d", res_addr, me.a); end
          checks++;
          if (res_data !== me.d) begin errors++; $display("FAIL res_data addr=%0d got=%h want=%h", me.a, res_data, me.d); end
        end
      end
      if (done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d want none", cyc);
        end else begin
          md = dq.pop_front();
          if (cyc != md.cyc) begin errors++; $display("FAIL done_cycle got=%0d want=%0d", cyc, md.cyc); end
          checks++;
          if (aborted !== md.ab) begin errors++; $display("FAIL done_aborted got=%b want=%b", aborted, md.ab); end
          checks++;
          if (busy !== 1'b0 || cyc - rise != md.blen) begin
            errors++;
            $display("FAIL busy_window got busy=%b len=%0d want busy=0 len=%0d", busy, cyc - rise, md.blen);
          end
`ifdef MAC_SEQ_ACCUM_EN
          checks++;
          if (acc_valid !== !md.ab) begin errors++; $display("FAIL acc_valid got=%b want=%b", acc_valid, !md.ab); end
          if (md.has_acc) begin
            checks++;
            if (int'($signed(acc_data[ACC_W-1:0])) != md.acc0) begin
              errors++;
              $display("FAIL acc_lane0 got=%0d want=%0d", int'($signed(acc_data[ACC_W-1:0])), md.acc0);
            end
          end
`endif
        end
      end
      if (chk_end) begin
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL res_missing left=%0d want=0", exp_q.size()); end
        checks++;
        if (dq.size() != 0) begin errors++; $display("FAIL done_missing left=%0d want=0", dq.size()); end
        checks++;
        if (iq.size() != 0) begin errors++; $display("FAIL issue_missing left=%0d want=0", iq.size()); end
      end
    end
  end
  task automatic sweep(input int base, input int cnt, input int hs, input int hl, input int ab);
    int s, t, n, last, dc;
    res_t r;
    done_t d;
    iss_t i;
    @(posedge clk); #1;
    start = 1; base_addr = AW'(base); count = (AW+1)'(cnt); s = cyc;
    n = cnt > 16 ? 16 : cnt;
    last = s;
    for (int k = 0; k < n; k++) begin
      t = s + 1 + k;
      if (hl > 0 && t >= s + hs) t += hl;
      if (ab == 0 || t < s + ab) begin
        i.cyc = t; i.a = AW'(base + k); iq.push_back(i);
        last = t;
        if (ab == 0) begin
          r.cyc = t + LAT + 1; r.a = AW'(base + k); r.d = pk((base + k) % 16);
          exp_q.push_back(r);
        end
      end
    end
    dc = ab > 0 ? s + ab + 2 : n == 0 ? s + 2 : last + LAT + 3;
    d.cyc = dc; d.ab = ab > 0; d.blen = dc - s - 1; d.has_acc = use_acc; d.acc0 = 23;
    dq.push_back(d);
    do begin
      @(posedge clk); #1;
      start = 0;
      hold  = hl > 0 && cyc >= s + hs && cyc < s + hs + hl;
      abort = ab > 0 && cyc == s + ab;
    end while (cyc < dc - 1);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  initial begin
    @(posedge clk); #1;
    chk_rst = 1;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    chk_rst = 0;
    sweep(0, 4, 0, 0, 0);
    chk_idle = 1;
    sweep(7, 0, 0, 0, 0);
    idle(2);
    chk_idle = 0;
    sweep(14, 4, 0, 0, 0);
    sweep(2, 8, 2, 3, 0);
    sweep(3, 8, 0, 0, 3);
    sweep(9, 2, 0, 0, 0);
    sweep(0, 20, 0, 0, 0);
    use_acc = 1;
    sweep(0, 3, 0, 0, 0);
    use_acc = 0;
    @(posedge clk); #1;
    start = 1; base_addr = 4'd5; count = 5'd8;
    @(posedge clk); #1;
    start = 0;
    idle(2);
    reset = 1;
    exp_q.delete(); dq.delete(); iq.delete();
    @(posedge clk); #1;
    reset = 0; chk_rst = 1;
    @(posedge clk); #1;
    chk_rst = 0; chk_idle = 1;
    idle(12);
    chk_idle = 0;
    sweep(11, 2, 0, 0, 0);
    @(posedge clk); #1;
    chk_end = 1;
    @(negedge clk); #1;
    chk_end = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
